// File: rtl/pkt_ctrl_mc_pkg.sv
// Shared types and helpers for the multi-channel packet controller.
package pkt_ctrl_mc_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_DATA,
        S_GAP,
        S_DONE
    } state_t;

    // Clocks from a word tick to its out_valid.
    localparam int RD_LAT    = 2;

    // The self-test word carries the channel above a 16-bit word index.
    localparam int PAT_IDX_W = 16;
    localparam int PAT_W     = 4 + PAT_IDX_W;

    function automatic int len_words(input logic [1:0] code, input int base);
        return base << code;
    endfunction

    function automatic logic [PAT_W-1:0] pattern_word(input logic [3:0]           ch,
                                                      input logic [PAT_IDX_W-1:0] idx);
        return {ch, idx};
    endfunction

endpackage

// File: rtl/pkt_period_timer.sv
// Word-period counter: pcnt runs 0..gap and wraps, tick marks the issue phase.
module pkt_period_timer #(
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             clr,
    input  logic [GAP_W-1:0] gap,
    input  logic [GAP_W-1:0] phase,
    output logic             tick
);

    logic [GAP_W-1:0] pcnt;

    // Free-running period counter, restarted by clr and frozen when en is low.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pcnt <= '0;
        end else if (en) begin
            if (clr || (pcnt >= gap)) begin
                pcnt <= '0;
            end else begin
                pcnt <= pcnt + GAP_W'(1);
            end
        end
    end

    assign tick = (pcnt == phase);

endmodule

// File: rtl/pkt_ctrl_mc.sv
// Round-robin packetiser: reads NUM_CH capture banks (or a self-test pattern)
// and emits fixed-length packets with a two-clock tick-to-valid latency.
module pkt_ctrl_mc
    import pkt_ctrl_mc_pkg::*;
#(
    parameter int DATA_W   = 18,
    parameter int NUM_CH   = 4,
    parameter int ADDR_W   = 12,
    parameter int BASE_LEN = 216,
    parameter int GAP_W    = 4,
    parameter int IDLE_W   = 8,
    parameter int CNT_W    = 16,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              sw_rstn,
    input  logic              clk_en,
    input  logic              cfg_self_test,
    input  logic [NUM_CH-1:0] cfg_ch_mask,
    input  logic [GAP_W-1:0]  cfg_gap,
    input  logic [GAP_W-1:0]  cfg_phase,
    input  logic [1:0]        cfg_len_code,
    input  logic [IDLE_W-1:0] cfg_idle_len,
    input  logic              start,
    input  logic              again,
    output logic              mem_rd_en,
    output logic [CH_W-1:0]   mem_rd_ch,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  pkt_cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    state_t            state;
    logic [NUM_CH-1:0] mask_l;
    logic [GAP_W-1:0]  gap_l;
    logic [GAP_W-1:0]  phase_l;
    logic [1:0]        len_code_l;
    logic [IDLE_W-1:0] idle_l;
    logic              st_l;
    logic [IDLE_W-1:0] gcnt;
    logic [CH_W-1:0]   cur_ch;
    logic [CH_W-1:0]   first_ch;
    logic [CH_W-1:0]   nxt_ch;
    logic              nxt_found;
    logic [ADDR_W-1:0] widx;
    logic [ADDR_W-1:0] last_idx;
    logic              drain;
    logic [1:0]        drain_cnt;
    logic              tick;
    logic              issue;
    logic              accept;
    logic              timer_clr;

    logic              vld_p1;
    logic              last_p1;
    logic [CH_W-1:0]   ch_p1;
    logic [ADDR_W-1:0] idx_p1;

    assign last_idx  = ADDR_W'(len_words(len_code_l, BASE_LEN) - 1);
    assign issue     = (state == S_DATA) && !drain && tick;
    assign accept    = ((state == S_IDLE) && start) || ((state == S_DONE) && (start || again));
    assign timer_clr = (state == S_PREP) || !sw_rstn;

    // The read strobe is decoded from registered state so memory data lands one clock later.
    assign mem_rd_en   = issue && !st_l;
    assign mem_rd_ch   = mem_rd_en ? cur_ch : '0;
    assign mem_rd_addr = mem_rd_en ? widx : '0;

    pkt_period_timer #(
        .GAP_W (GAP_W)
    ) u_timer (
        .clk   (clk),
        .rstn  (rstn),
        .en    (clk_en),
        .clr   (timer_clr),
        .gap   (gap_l),
        .phase (phase_l),
        .tick  (tick)
    );

    // Lowest enabled channel of the incoming mask, used when a run starts.
    always_comb begin
        first_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (cfg_ch_mask[i]) first_ch = CH_W'(i);
        end
    end

    // Next enabled channel above the current one in the latched mask.
    always_comb begin
        nxt_found = 1'b0;
        nxt_ch    = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask_l[i] && (i > int'(cur_ch))) begin
                nxt_found = 1'b1;
                nxt_ch    = CH_W'(i);
            end
        end
    end

    // Main control FSM with latched configuration and registered busy/done.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= S_IDLE;
            mask_l     <= '0;
            gap_l      <= '0;
            phase_l    <= '0;
            len_code_l <= '0;
            idle_l     <= '0;
            st_l       <= 1'b0;
            gcnt       <= '0;
            cur_ch     <= '0;
            widx       <= '0;
            drain      <= 1'b0;
            drain_cnt  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else if (clk_en) begin
            if (!sw_rstn) begin
                state      <= S_IDLE;
                mask_l     <= '0;
                gap_l      <= '0;
                phase_l    <= '0;
                len_code_l <= '0;
                idle_l     <= '0;
                st_l       <= 1'b0;
                gcnt       <= '0;
                cur_ch     <= '0;
                widx       <= '0;
                drain      <= 1'b0;
                drain_cnt  <= '0;
                busy       <= 1'b0;
                done       <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (accept) begin
                            state <= S_PREP;
                            busy  <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        if (accept) begin
                            state <= S_PREP;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end
                    end
                    S_PREP: begin
                        mask_l     <= cfg_ch_mask;
                        gap_l      <= cfg_gap;
                        phase_l    <= (cfg_phase > cfg_gap) ? cfg_gap : cfg_phase;
                        len_code_l <= cfg_len_code;
                        idle_l     <= cfg_idle_len;
                        st_l       <= cfg_self_test;
                        widx       <= '0;
                        gcnt       <= '0;
                        drain      <= 1'b0;
                        if (cfg_ch_mask == '0) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state  <= S_DATA;
                            cur_ch <= first_ch;
                        end
                    end
                    S_DATA: begin
                        if (drain) begin
                            // Hold off DONE until the final word has reached the output.
                            if (drain_cnt == '0) begin
                                state <= S_DONE;
                                drain <= 1'b0;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                drain_cnt <= drain_cnt - 2'd1;
                            end
                        end else if (tick) begin
                            if (widx == last_idx) begin
                                widx <= '0;
                                if (idle_l != '0) begin
                                    state <= S_GAP;
                                    gcnt  <= '0;
                                end else if (nxt_found) begin
                                    cur_ch <= nxt_ch;
                                end else begin
                                    drain     <= 1'b1;
                                    drain_cnt <= 2'(RD_LAT - 2);
                                end
                            end else begin
                                widx <= widx + ADDR_W'(1);
                            end
                        end
                    end
                    S_GAP: begin
                        if (tick) begin
                            if (gcnt == idle_l - IDLE_W'(1)) begin
                                if (nxt_found) begin
                                    state  <= S_DATA;
                                    cur_ch <= nxt_ch;
                                end else begin
                                    state <= S_DONE;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                end
                            end else begin
                                gcnt <= gcnt + IDLE_W'(1);
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // Stage p1: capture the word identity at the tick (data only, no reset needed).
    always_ff @(posedge clk) begin
        if (clk_en && issue) begin
            ch_p1  <= cur_ch;
            idx_p1 <= widx;
        end
    end

    // Stage p1 control and output stage: valid strobe, data mux and packet counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_p1    <= 1'b0;
            last_p1   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            pkt_cnt   <= '0;
        end else if (clk_en) begin
            if (!sw_rstn) begin
                vld_p1    <= 1'b0;
                last_p1   <= 1'b0;
                out_valid <= 1'b0;
                out_data  <= '0;
                pkt_cnt   <= '0;
            end else begin
                vld_p1    <= issue;
                last_p1   <= issue && (widx == last_idx);
                out_valid <= vld_p1;
                if (!vld_p1) begin
                    out_data <= '0;
                end else if (st_l) begin
                    out_data <= DATA_W'(pattern_word(4'(ch_p1), PAT_IDX_W'(idx_p1)));
                end else begin
                    out_data <= mem_rd_data;
                end
                if (accept) begin
                    pkt_cnt <= '0;
                end else if (vld_p1 && last_p1) begin
                    pkt_cnt <= sat_inc(pkt_cnt);
                end
            end
        end
    end

endmodule

// File: tb/tb_pkt_ctrl_mc.sv
// Directed bench for pkt_ctrl_mc with a behavioural capture-memory model.
module tb_pkt_ctrl_mc;

    localparam int DATA_W = 18;
    localparam int NUM_CH = 4;
    localparam int ADDR_W = 12;
    localparam int GAP_W  = 4;
    localparam int IDLE_W = 8;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rstn;
    logic              sw_rstn;
    logic              clk_en;
    logic              cfg_self_test;
    logic [NUM_CH-1:0] cfg_ch_mask;
    logic [GAP_W-1:0]  cfg_gap;
    logic [GAP_W-1:0]  cfg_phase;
    logic [1:0]        cfg_len_code;
    logic [IDLE_W-1:0] cfg_idle_len;
    logic              start;
    logic              again;
    logic              mem_rd_en;
    logic [1:0]        mem_rd_ch;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [DATA_W-1:0] mem_rd_data = '0;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  pkt_cnt;

    int n_chk = 0;
    int n_err = 0;

    int                vcyc[$];
    logic [DATA_W-1:0] vdat[$];
    int                pcq[$];
    int                rcyc[$];
    int                raddr[$];
    int                rch[$];
    int                done_cyc;

    always #5 clk = ~clk;

    pkt_ctrl_mc #(
        .DATA_W   (DATA_W),
        .NUM_CH   (NUM_CH),
        .ADDR_W   (ADDR_W),
        .BASE_LEN (216),
        .GAP_W    (GAP_W),
        .IDLE_W   (IDLE_W),
        .CNT_W    (CNT_W)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .sw_rstn       (sw_rstn),
        .clk_en        (clk_en),
        .cfg_self_test (cfg_self_test),
        .cfg_ch_mask   (cfg_ch_mask),
        .cfg_gap       (cfg_gap),
        .cfg_phase     (cfg_phase),
        .cfg_len_code  (cfg_len_code),
        .cfg_idle_len  (cfg_idle_len),
        .start         (start),
        .again         (again),
        .mem_rd_en     (mem_rd_en),
        .mem_rd_ch     (mem_rd_ch),
        .mem_rd_addr   (mem_rd_addr),
        .mem_rd_data   (mem_rd_data),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .busy          (busy),
        .done          (done),
        .pkt_cnt       (pkt_cnt)
    );

    function automatic logic [DATA_W-1:0] mem_word(input int ch, input int addr);
        return DATA_W'(addr * 97 + ch * 5003 + 32'h0ABC);
    endfunction

    // Capture memory: synchronous read, data valid one clock after the strobe.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem_word(int'(mem_rd_ch), int'(mem_rd_addr));
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_cfg(input logic st, input logic [NUM_CH-1:0] mask, input int gap,
                           input int phase, input int code, input int idle);
        cfg_self_test = st;
        cfg_ch_mask   = mask;
        cfg_gap       = GAP_W'(gap);
        cfg_phase     = GAP_W'(phase);
        cfg_len_code  = 2'(code);
        cfg_idle_len  = IDLE_W'(idle);
    endtask

    // Pulse start/again for one clock; returns at the negedge of the PREP cycle.
    task automatic launch(input logic st, input logic ag);
        @(negedge clk);
        start = st;
        again = ag;
        @(negedge clk);
        start = 1'b0;
        again = 1'b0;
    endtask

    // Record reads and valid words per cycle (c=0 is the first cycle after PREP) until done.
    task automatic collect(input int max_cyc, input int pulse_at);
        vcyc.delete(); vdat.delete(); pcq.delete();
        rcyc.delete(); raddr.delete(); rch.delete();
        done_cyc = -1;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            if (out_valid) begin
                vcyc.push_back(c);
                vdat.push_back(out_data);
                pcq.push_back(int'(pkt_cnt));
            end
            if (mem_rd_en) begin
                rcyc.push_back(c);
                raddr.push_back(int'(mem_rd_addr));
                rch.push_back(int'(mem_rd_ch));
            end
            start = (c == pulse_at);
            if (done) begin
                done_cyc = c;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic check_mem_run(input string p);
        int bad_rd;
        int bad_v;
        bad_rd = 0;
        bad_v  = 0;
        check_eq({p, "_nreads"}, rcyc.size(), 432);
        for (int i = 0; i < rcyc.size(); i++) begin
            if (rcyc[i] != i || raddr[i] != i || rch[i] != 0) bad_rd++;
        end
        check_eq({p, "_read_seq_bad"}, bad_rd, 0);
        check_eq({p, "_nvalid"}, vcyc.size(), 432);
        for (int i = 0; i < vcyc.size(); i++) begin
            if (vcyc[i] != i + 2 || vdat[i] !== mem_word(0, i)) bad_v++;
        end
        check_eq({p, "_valid_bad"}, bad_v, 0);
        check_eq({p, "_cnt_before_last"}, (pcq.size() > 430) ? pcq[430] : 99, 0);
        check_eq({p, "_cnt_at_last"}, (pcq.size() > 431) ? pcq[431] : 99, 1);
        check_eq({p, "_done_cyc"}, done_cyc, 433);
        check_eq({p, "_pkt_cnt"}, pkt_cnt, 1);
        check_eq({p, "_busy_end"}, busy, 0);
    endtask

    initial begin
        int bad;
        int extra;
        logic [31:0] expw;

        rstn    = 1'b0;
        sw_rstn = 1'b1;
        clk_en  = 1'b1;
        start   = 1'b0;
        again   = 1'b0;
        set_cfg(1'b0, 4'b0001, 0, 0, 0, 0);

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_data", out_data, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_pkt_cnt", pkt_cnt, 0);
        check_eq("rst_rd_en", mem_rd_en, 0);
        rstn = 1'b1;

        // clk_en low in IDLE: a start pulse must not be seen
        @(negedge clk);
        clk_en = 1'b0;
        start  = 1'b1;
        repeat (10) @(negedge clk);
        check_eq("ce_busy", busy, 0);
        check_eq("ce_done", done, 0);
        start  = 1'b0;
        clk_en = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("ce_busy_after", busy, 0);
        check_eq("ce_done_after", done, 0);

        // Self-test, two packets on ch0 and ch2 with one idle period
        set_cfg(1'b1, 4'b0101, 4, 1, 0, 1);
        launch(1'b1, 1'b0);
        check_eq("st_busy_prep", busy, 1);
        collect(3000, -1);
        check_eq("st_done_seen", 32'(done_cyc >= 0), 1);
        check_eq("st_nvalid", vcyc.size(), 432);
        check_eq("st_nreads", rcyc.size(), 0);
        check_eq("st_first_cyc", (vcyc.size() > 0) ? vcyc[0] : -1, 3);
        bad = 0;
        for (int i = 0; i < vdat.size(); i++) begin
            expw = (i < 216) ? 32'(i) : (32'h20000 | 32'(i - 216));
            if (vdat[i] !== expw[DATA_W-1:0]) bad++;
            if (i > 0 && (vcyc[i] - vcyc[i-1]) != ((i == 216) ? 10 : 5)) bad++;
        end
        check_eq("st_data_spacing_bad", bad, 0);
        check_eq("st_cnt_before_last1", (pcq.size() > 214) ? pcq[214] : 99, 0);
        check_eq("st_cnt_at_last1", (pcq.size() > 215) ? pcq[215] : 99, 1);
        check_eq("st_pkt_cnt", pkt_cnt, 2);
        check_eq("st_done", done, 1);
        check_eq("st_busy_end", busy, 0);

        // Memory mode, back-to-back words; a start pulse mid-run must be ignored
        set_cfg(1'b0, 4'b0001, 0, 0, 1, 0);
        launch(1'b1, 1'b0);
        check_eq("mem_busy_prep", busy, 1);
        check_eq("mem_cnt_cleared", pkt_cnt, 0);
        collect(600, 100);
        check_mem_run("mem");

        // again from DONE repeats the run identically
        launch(1'b0, 1'b1);
        collect(600, -1);
        check_mem_run("again");

        // Empty mask: straight to DONE with nothing emitted
        set_cfg(1'b0, 4'b0000, 0, 0, 0, 0);
        launch(1'b1, 1'b0);
        collect(20, -1);
        check_eq("m0_done_cyc", done_cyc, 0);
        check_eq("m0_nvalid", vcyc.size(), 0);
        check_eq("m0_nreads", rcyc.size(), 0);
        check_eq("m0_pkt_cnt", pkt_cnt, 0);
        check_eq("m0_busy", busy, 0);

        // Phase clamp on ch1, launched with start and again together
        set_cfg(1'b1, 4'b0010, 2, 7, 0, 0);
        launch(1'b1, 1'b1);
        collect(900, -1);
        check_eq("pc_nvalid", vcyc.size(), 216);
        check_eq("pc_nreads", rcyc.size(), 0);
        check_eq("pc_first_cyc", (vcyc.size() > 0) ? vcyc[0] : -1, 4);
        bad = 0;
        for (int i = 0; i < vdat.size(); i++) begin
            expw = 32'h10000 | 32'(i);
            if (vdat[i] !== expw[DATA_W-1:0]) bad++;
            if (i > 0 && (vcyc[i] - vcyc[i-1]) != 3) bad++;
        end
        check_eq("pc_data_spacing_bad", bad, 0);
        check_eq("pc_done_cyc", done_cyc, 649);
        check_eq("pc_pkt_cnt", pkt_cnt, 1);
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid || mem_rd_en || busy) extra++;
        end
        check_eq("pc_single_run", extra, 0);
        check_eq("pc_done_hold", done, 1);

        // Asynchronous reset in the middle of a packet
        set_cfg(1'b1, 4'b0001, 0, 0, 0, 0);
        launch(1'b1, 1'b0);
        repeat (10) @(negedge clk);
        check_eq("ar_pre_valid", out_valid, 1);
        #2 rstn = 1'b0;
        #1;
        check_eq("ar_valid", out_valid, 0);
        check_eq("ar_data", out_data, 0);
        check_eq("ar_busy", busy, 0);
        check_eq("ar_done", done, 0);
        check_eq("ar_pkt_cnt", pkt_cnt, 0);
        check_eq("ar_rd_en", mem_rd_en, 0);
        @(negedge clk);
        rstn = 1'b1;
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid || busy) extra++;
        end
        check_eq("ar_quiet_after", extra, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
